// File: rtl/program_loader.sv
// program_loader: boot-time loader feeding the instruction-memory write port.
// Accepts a length-prefixed byte stream, assembles little-endian 32-bit words,
// writes them to word addresses 0..N-1 and keeps the core held until the image
// is complete.
//
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN
//   When defined, the stream carries a trailing XOR checksum byte over all
//   data bytes, and a mismatch ends the load in ERROR.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | out of reset, waiting for start
// LEN_LO | waiting for LEN[7:0]
// LEN_HI | waiting for LEN[15:8]; length is range-checked on acceptance
// DATA   | collecting data bytes, one write per completed word
// DRAIN  | final write in flight, no bytes accepted (checksum off)
// CSUM   | final write in flight, waiting for checksum byte (checksum on)
// DONE   | image loaded, core released; start begins a new load
// ERROR  | load rejected, core held; start begins a new load

module program_loader #(
    parameter int data_bits           = 32,
    parameter int memory_size         = 1024,
    parameter int memory_address_bits = $clog2(memory_size)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           byte_valid,
    input  logic [7:0]                     byte_data,
    output logic                           byte_ready,
    output logic                           imem_write_enable,
    output logic [memory_address_bits-1:0] imem_address,
    output logic [data_bits-1:0]           imem_write_data,
    output logic                           core_hold,
    output logic                           done,
    output logic                           error,
    output logic [memory_address_bits:0]   words_loaded
);

    localparam int CNT_W = memory_address_bits + 1;
    // Wide enough to hold both the 16-bit LEN field and words_loaded + 1.
    localparam int CMP_W = (CNT_W > 16) ? CNT_W + 1 : 17;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CMP_W-1:0] MAX_LEN = CMP_W'(memory_size);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        DRAIN  = 3'd4,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CSUM   = 3'd5,
`endif
        DONE   = 3'd6,
        ERROR  = 3'd7
    } state_t;

    state_t state;
    state_t next_state;

    logic [15:0] len_q;
    logic [23:0] word_sr;
    logic [1:0]  byte_idx;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    logic        accept;
    logic        start_load;
    logic        last_byte;
    logic        last_word;
    logic [15:0] len_full;
    logic        len_bad;

    logic        byte_ready_d;
    logic        core_hold_d;
    logic        done_d;
    logic        error_d;

    assign accept     = byte_valid && byte_ready;
    assign start_load = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign last_byte  = (byte_idx == 2'd3);
    // words_loaded already counts every earlier word, so it is the index of
    // the word now being assembled.
    assign last_word  = (CMP_W'(len_q) == (CMP_W'(words_loaded) + CMP_W'(1)));
    assign len_full   = {byte_data, len_q[7:0]};
    assign len_bad    = (len_full == 16'd0) || (CMP_W'(len_full) > MAX_LEN);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode from the current state, start and byte acceptance.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    next_state = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    next_state = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    next_state = len_bad ? ERROR : DATA;
                end
            end
            DATA: begin
                if (accept && last_byte && last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    next_state = CSUM;
`else
                    next_state = DRAIN;
`endif
                end
            end
            DRAIN: begin
                next_state = DONE;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    next_state = (byte_data == csum_q) ? DONE : ERROR;
                end
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output levels for the state being entered, so the flops below present
    // them in the same cycle the state register does.
    always_comb begin
        byte_ready_d = 1'b0;
        core_hold_d  = 1'b1;
        done_d       = 1'b0;
        error_d      = 1'b0;
        case (next_state)
            LEN_LO, LEN_HI, DATA: begin
                byte_ready_d = 1'b1;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CSUM: begin
                byte_ready_d = 1'b1;
            end
`endif
            DONE: begin
                core_hold_d = 1'b0;
                done_d      = 1'b1;
            end
            ERROR: begin
                error_d = 1'b1;
            end
            default: begin
                byte_ready_d = 1'b0;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_ready <= 1'b0;
            core_hold  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            byte_ready <= byte_ready_d;
            core_hold  <= core_hold_d;
            done       <= done_d;
            error      <= error_d;
        end
    end

    // Length capture, word assembly, write strobe and word count.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q             <= '0;
            word_sr           <= '0;
            byte_idx          <= '0;
            imem_write_enable <= 1'b0;
            imem_address      <= '0;
            imem_write_data   <= '0;
            words_loaded      <= '0;
        end else begin
            imem_write_enable <= 1'b0;

            // The count advances as the write cycle closes.
            if (imem_write_enable) begin
                words_loaded <= words_loaded + CNT_ONE;
            end

            if (start_load) begin
                words_loaded <= '0;
                byte_idx     <= '0;
            end

            if (accept) begin
                case (state)
                    LEN_LO: begin
                        len_q[7:0] <= byte_data;
                    end
                    LEN_HI: begin
                        len_q[15:8] <= byte_data;
                    end
                    DATA: begin
                        // Bytes arrive LSB first; shifting in from the top
                        // leaves byte 0 in the low lane after three bytes.
                        word_sr  <= {byte_data, word_sr[23:8]};
                        byte_idx <= byte_idx + 2'd1;
                        if (last_byte) begin
                            imem_write_enable <= 1'b1;
                            imem_address      <= words_loaded[memory_address_bits-1:0];
                            imem_write_data   <= {byte_data, word_sr};
                        end
                    end
                    default: begin
                        len_q <= len_q;
                    end
                endcase
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Running XOR over the data bytes of the current load.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else if (start_load) begin
            csum_q <= '0;
        end else if (accept && (state == DATA)) begin
            csum_q <= csum_q ^ byte_data;
        end
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: drives length-prefixed byte streams into program_loader
// and checks every cycle against a byte-count level model of the loader.
// Honours PROGRAM_LOADER_CHECKSUM_EN in the same way as the design.

module tb_program_loader;

    localparam int MEM = 1024;
    localparam int AW  = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_write_enable;
    logic [AW-1:0] imem_address;
    logic [31:0]   imem_write_data;
    logic          core_hold;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    program_loader #(
        .data_bits   (32),
        .memory_size (MEM)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .byte_valid        (byte_valid),
        .byte_data         (byte_data),
        .byte_ready        (byte_ready),
        .imem_write_enable (imem_write_enable),
        .imem_address      (imem_address),
        .imem_write_data   (imem_write_data),
        .core_hold         (core_hold),
        .done              (done),
        .error             (error),
        .words_loaded      (words_loaded)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (byte-count level) ----------------
    bit          m_init = 0;
    bit          m_busy;     // a load is consuming bytes
    bit          m_drain;    // last data byte taken, final write in flight
    int          m_status;   // 0 none, 1 loaded, 2 rejected
    int          m_nb;       // bytes accepted in this load
    int          m_n;        // word count from the length field
    logic [7:0]  m_lo;
    logic [7:0]  m_xor;
    logic [31:0] m_cur;
    int          m_wl;
    bit          m_acc;

    bit          e_ready;
    bit          e_we;
    int          e_addr;
    logic [31:0] e_data;
    bit          e_hold;
    bit          e_done;
    bit          e_err;

    always @(posedge clk) begin
        int k;
        bit acc;
        bit prev_we;
        acc = 0;
        if (reset) begin
            m_init   = 1;
            m_busy   = 0;
            m_drain  = 0;
            m_status = 0;
            m_nb     = 0;
            m_wl     = 0;
            e_we     = 0;
            e_addr   = 0;
            e_data   = '0;
        end else begin
            prev_we = e_we;
            e_we    = 0;
            if (prev_we) m_wl++;
            if (!m_busy && !m_drain && start) begin
                m_busy   = 1;
                m_status = 0;
                m_nb     = 0;
                m_wl     = 0;
                m_xor    = '0;
            end else if (m_busy && byte_valid) begin
                acc = 1;
                if (m_nb == 0) begin
                    m_lo = byte_data;
                end else if (m_nb == 1) begin
                    m_n = int'({byte_data, m_lo});
                    if (m_n == 0 || m_n > MEM) begin
                        m_busy   = 0;
                        m_status = 2;
                    end
                end else if (m_nb < 2 + 4 * m_n) begin
                    k = m_nb - 2;
                    m_cur[(k % 4) * 8 +: 8] = byte_data;
                    m_xor = m_xor ^ byte_data;
                    if (k % 4 == 3) begin
                        e_we   = 1;
                        e_addr = k / 4;
                        e_data = m_cur;
                    end
`ifndef PROGRAM_LOADER_CHECKSUM_EN
                    if (k == 4 * m_n - 1) begin
                        m_busy  = 0;
                        m_drain = 1;
                    end
`endif
                end else begin
                    m_busy   = 0;
                    m_status = (byte_data == m_xor) ? 1 : 2;
                end
                m_nb++;
            end else if (m_drain) begin
                m_drain  = 0;
                m_status = 1;
            end
        end
        m_acc   = acc;
        e_ready = m_busy;
        e_hold  = (m_status != 1);
        e_done  = (m_status == 1);
        e_err   = (m_status == 2);
    end

    // ---------------- per-cycle compare and write capture ----------------
    logic [31:0] dut_mem [0:MEM-1];
    int          wr_count = 0;

    always @(negedge clk) begin
        if (m_init) begin
            chk("byte_ready",   32'(byte_ready),        32'(e_ready));
            chk("write_enable", 32'(imem_write_enable), 32'(e_we));
            chk("core_hold",    32'(core_hold),         32'(e_hold));
            chk("done",         32'(done),              32'(e_done));
            chk("error",        32'(error),             32'(e_err));
            chk("words_loaded", 32'(words_loaded),      32'(m_wl));
            if (e_we) begin
                chk("write_address", 32'(imem_address), 32'(e_addr));
                chk("write_data",    imem_write_data,   e_data);
            end
        end
        if (imem_write_enable === 1'b1) begin
            dut_mem[imem_address] = imem_write_data;
            wr_count++;
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] stream [$];

    task automatic drive_byte(input logic [7:0] b, input int gap);
        int guard;
        if (gap > 0) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            repeat (gap) @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (!m_acc && guard < 20);
        if (!m_acc) begin
            bad++;
            $display("FAIL accept_timeout: byte %h not taken within %0d cycles", b, guard);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle before every byte, 2 random.
    task automatic send_bytes(input int gap_mode, input int start_at, input int count);
        for (int i = 0; i < count; i++) begin
            int g;
            g = 0;
            if (gap_mode == 1) g = 1;
            else if (gap_mode == 2 && $urandom_range(0, 3) == 0) g = $urandom_range(1, 3);
            if (i == start_at) start = 1'b1;
            drive_byte(stream[i], g);
            start = 1'b0;
        end
    endtask

    task automatic build_stream(input int n, input bit good_csum);
        logic [7:0] x;
        logic [7:0] b;
        logic [15:0] len;
        stream.delete();
        len = 16'(n);
        stream.push_back(len[7:0]);
        stream.push_back(len[15:8]);
        x = '0;
        if (n >= 1 && n <= MEM) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                x = x ^ b;
                stream.push_back(b);
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            stream.push_back(good_csum ? x : (x ^ 8'(1 << $urandom_range(0, 7))));
`endif
        end
    endtask

    task automatic load_image_n2();
        logic [7:0] img [10];
        logic [7:0] x;
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        stream.delete();
        x = '0;
        for (int i = 0; i < 10; i++) begin
            stream.push_back(img[i]);
            if (i >= 2) x = x ^ img[i];
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        stream.push_back(x);
`endif
    endtask

    task automatic check_n2_result(input string tag, input int wr_before);
        chk({tag, "_word0"},  dut_mem[0], 32'h00A00513);
        chk({tag, "_word1"},  dut_mem[1], 32'h00100593);
        chk({tag, "_writes"}, 32'(wr_count - wr_before), 32'd2);
        chk({tag, "_done"},   32'(done), 32'd1);
        chk({tag, "_hold"},   32'(core_hold), 32'd0);
        chk({tag, "_count"},  32'(words_loaded), 32'd2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        int n;
        int sel;
        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;
        repeat (3) @(negedge clk);

        // Reset values.
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_we",         32'(imem_write_enable), 32'd0);
        chk("rst_addr",       32'(imem_address), 32'd0);
        chk("rst_data",       imem_write_data, 32'd0);
        chk("rst_hold",       32'(core_hold), 32'd1);
        chk("rst_done",       32'(done), 32'd0);
        chk("rst_error",      32'(error), 32'd0);
        chk("rst_count",      32'(words_loaded), 32'd0);

        // Start asserted together with reset is ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("start_in_reset_ready", 32'(byte_ready), 32'd0);

        // N=2 image, back-to-back bytes.
        load_image_n2();
        dut_mem[0] = '0; dut_mem[1] = '0;
        wr0 = wr_count;
        pulse_start();
        send_bytes(0, -1, stream.size());
        repeat (3) @(negedge clk);
        check_n2_result("n2_solid", wr0);

        // start in DONE: next edge holds the core and clears the count.
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_hold",  32'(core_hold), 32'd1);
        chk("restart_count", 32'(words_loaded), 32'd0);
        chk("restart_done",  32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;

        // Same image with valid toggling and a stray start during DATA.
        dut_mem[0] = '0; dut_mem[1] = '0;
        wr0 = wr_count;
        send_bytes(1, 5, stream.size());
        repeat (3) @(negedge clk);
        check_n2_result("n2_toggle", wr0);

        // Length 0 and length above the memory depth are rejected.
        stream.delete();
        stream.push_back(8'h00); stream.push_back(8'h00);
        wr0 = wr_count;
        pulse_start();
        send_bytes(0, -1, 2);
        repeat (2) @(negedge clk);
        chk("len0_error",  32'(error), 32'd1);
        chk("len0_ready",  32'(byte_ready), 32'd0);
        chk("len0_hold",   32'(core_hold), 32'd1);
        chk("len0_writes", 32'(wr_count - wr0), 32'd0);

        stream.delete();
        stream.push_back(8'h01); stream.push_back(8'h04);
        pulse_start();
        send_bytes(0, -1, 2);
        repeat (2) @(negedge clk);
        chk("len401_error",  32'(error), 32'd1);
        chk("len401_ready",  32'(byte_ready), 32'd0);
        chk("len401_writes", 32'(wr_count - wr0), 32'd0);

        // Reset after 6 data bytes of an N=3 load, then a full reload.
        build_stream(3, 1'b1);
        pulse_start();
        send_bytes(0, -1, 8);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wr0 = wr_count;
        chk("midrst_hold",  32'(core_hold), 32'd1);
        chk("midrst_ready", 32'(byte_ready), 32'd0);
        chk("midrst_count", 32'(words_loaded), 32'd0);
        repeat (4) @(negedge clk);
        chk("midrst_no_write", 32'(wr_count - wr0), 32'd0);
        for (int i = 0; i < 3; i++) dut_mem[i] = '0;
        pulse_start();
        send_bytes(0, -1, stream.size());
        repeat (3) @(negedge clk);
        chk("reload_count", 32'(words_loaded), 32'd3);
        chk("reload_done",  32'(done), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("reload_word", dut_mem[i],
                {stream[2 + 4 * i + 3], stream[2 + 4 * i + 2], stream[2 + 4 * i + 1], stream[2 + 4 * i]});
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Checksum accepted and rejected.
        stream.delete();
        stream.push_back(8'h01); stream.push_back(8'h00);
        stream.push_back(8'h13); stream.push_back(8'h05);
        stream.push_back(8'hA0); stream.push_back(8'h00);
        stream.push_back(8'hB6);
        dut_mem[0] = '0;
        pulse_start();
        send_bytes(0, -1, stream.size());
        repeat (2) @(negedge clk);
        chk("csum_ok_done", 32'(done), 32'd1);
        chk("csum_ok_word", dut_mem[0], 32'h00A00513);
        stream[6] = 8'hB7;
        dut_mem[0] = '0;
        pulse_start();
        send_bytes(0, -1, stream.size());
        repeat (2) @(negedge clk);
        chk("csum_bad_error", 32'(error), 32'd1);
        chk("csum_bad_hold",  32'(core_hold), 32'd1);
        chk("csum_bad_word",  dut_mem[0], 32'h00A00513);
`endif

        // Randomized loads, checked cycle by cycle against the model.
        for (int t = 0; t < 30; t++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      n = 0;
            else if (sel == 1) n = MEM + 1 + $urandom_range(0, 200);
            else if (sel == 2) n = 16'hFFFF;
            else               n = $urandom_range(1, 6);
            build_stream(n, $urandom_range(0, 1) == 1);
            pulse_start();
            send_bytes(2, $urandom_range(0, stream.size() - 1), stream.size());
            repeat (3) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
